// File: rtl/conv_out_framer_pkg.sv
// conv_out_framer_pkg: shared accelerator widths, lane count and framer FSM state encoding
package conv_out_framer_pkg;
  localparam int DATA_W = 64;
  localparam int DIM_W = 16;
  localparam int LANES = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/conv_out_framer_if.sv
// conv_out_framer_if: ConvOutput result stream (sValid/sReady/sData) and writeback stream (mData_*); slave = framer, master = environment
interface conv_out_framer_if #(parameter int DATA_W = conv_out_framer_pkg::DATA_W);
  logic sValid;
  logic sReady;
  logic [DATA_W-1:0] sData;
  logic mData_valid;
  logic mData_ready;
  logic [DATA_W-1:0] mData_payload;
  logic mData_rowlast;
  logic mData_last;
  modport master (
    output sValid, sData, mData_ready,
    input sReady, mData_valid, mData_payload, mData_rowlast, mData_last
  );
  modport slave (
    input sValid, sData, mData_ready,
    output sReady, mData_valid, mData_payload, mData_rowlast, mData_last
  );
endinterface

// File: rtl/conv_out_framer_stream_skid_buf.sv
// stream_skid_buf: 2-entry registered skid buffer (clk, rst, in_valid/in_ready/in_data -> out_valid/out_ready/out_data); in_ready depends only on registered state
module stream_skid_buf #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_v;
  logic [W-1:0] skid_d;
  logic         in_fire;
  assign in_ready = !skid_v;
  assign in_fire = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_v || in_fire;
      if (skid_v) out_data <= skid_d;
      else if (in_fire) out_data <= in_data;
      skid_v <= 1'b0;
    end else if (in_fire) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end
endmodule

// File: rtl/conv_out_framer.sv
// conv_out_framer: tags conv output beats with rowlast/last per latched layer dims (clk, reset, start, In_Channel/Matrix_Col/Matrix_Row, bus streams, LayerEnd)
module conv_out_framer
  import conv_out_framer_pkg::*;
#(
  parameter int DATA_W = conv_out_framer_pkg::DATA_W,
  parameter int DIM_W = conv_out_framer_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] In_Channel,
  input  logic [DIM_W-1:0] Matrix_Col,
  input  logic [DIM_W-1:0] Matrix_Row,
  conv_out_framer_if.slave bus,
  output logic             LayerEnd
);
  state_t           state;
  logic [DIM_W-1:0] bpp, cols, rows;
  logic [DIM_W-1:0] chan, col, row;
  logic             last_in;
  logic [DIM_W:0]   ch_round;
  logic [DIM_W-1:0] bpp_in;
  logic             skid_ready, s_fire;
  logic             chan_end, col_end, row_end;
  logic             rowlast_tag, last_tag;
  logic [DATA_W+1:0] out_word;
  assign ch_round = {1'b0, In_Channel} + (DIM_W+1)'(LANES - 1);
  assign bpp_in = DIM_W'(ch_round / (DIM_W+1)'(LANES));
  assign bus.sReady = state == RUN && skid_ready && !last_in;
  assign s_fire = bus.sValid && bus.sReady;
  assign chan_end = chan == bpp - 1'b1;
  assign col_end = col == cols - 1'b1;
  assign row_end = row == rows - 1'b1;
  assign rowlast_tag = chan_end && col_end;
  assign last_tag = rowlast_tag && row_end;
  stream_skid_buf #(.W(DATA_W + 2)) u_skid (
    .clk(clk),
    .rst(reset),
    .in_valid(s_fire),
    .in_ready(skid_ready),
    .in_data({last_tag, rowlast_tag, bus.sData}),
    .out_valid(bus.mData_valid),
    .out_ready(bus.mData_ready),
    .out_data(out_word)
  );
  assign bus.mData_payload = out_word[DATA_W-1:0];
  assign bus.mData_rowlast = out_word[DATA_W];
  assign bus.mData_last = out_word[DATA_W+1];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bpp <= '0;
      cols <= '0;
      rows <= '0;
      chan <= '0;
      col <= '0;
      row <= '0;
      last_in <= 1'b0;
      LayerEnd <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          bpp <= bpp_in;
          cols <= Matrix_Col;
          rows <= Matrix_Row;
          chan <= '0;
          col <= '0;
          row <= '0;
          last_in <= 1'b0;
          state <= (In_Channel == '0 || Matrix_Col == '0 || Matrix_Row == '0) ? DONE : RUN;
          LayerEnd <= In_Channel == '0 || Matrix_Col == '0 || Matrix_Row == '0;
        end
        RUN: begin
          if (s_fire) begin
            chan <= chan_end ? '0 : chan + 1'b1;
            col <= chan_end ? (col_end ? '0 : col + 1'b1) : col;
            row <= rowlast_tag ? (row_end ? '0 : row + 1'b1) : row;
            last_in <= last_in || last_tag;
          end
          if (bus.mData_valid && bus.mData_ready && bus.mData_last) begin
            state <= DONE;
            LayerEnd <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          LayerEnd <= 1'b0;
          last_in <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_out_framer.md
CONV_OUT_FRAMER -- requirements
Module: conv_out_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning beat width (8 int8 lanes).
REQ-002 SHALL have parameter DIM_W, default 16, meaning width of each dimension input.
REQ-003 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that latches dimensions and arms a layer.
REQ-006 SHALL have port In_Channel, input, DIM_W, output channels per pixel.
REQ-007 SHALL have port Matrix_Col, input, DIM_W, output pixels per row.
REQ-008 SHALL have port Matrix_Row, input, DIM_W, output rows per layer.
REQ-009 SHALL have ports sValid, input, 1; sReady, output, 1; sData, input, DATA_W, forming the ConvOutput result stream.
REQ-010 SHALL have ports mData_valid, output, 1; mData_ready, input, 1; mData_payload, output, DATA_W, forming the writeback stream.
REQ-011 SHALL have port mData_rowlast, output, 1, high on the last beat of each output row.
REQ-012 SHALL have port mData_last, output, 1, high on the last beat of the layer.
REQ-013 SHALL have port LayerEnd, output, 1, one-cycle pulse when the layer completes.

Function
REQ-014 SHALL compute beats-per-pixel BPP = ceil(In_Channel/8) and latch BPP, Matrix_Col and Matrix_Row on start while in IDLE.
REQ-015 SHALL implement states IDLE -> RUN (on start) -> DONE (on handshake of the beat carrying mData_last) -> IDLE (after one cycle).
REQ-016 SHALL pulse LayerEnd for exactly the one cycle the FSM is in DONE.
REQ-017 SHALL ignore start while in RUN or DONE.
REQ-018 SHALL hold sReady low in IDLE and DONE, and accept input only in RUN.
REQ-019 SHALL pass sData to mData_payload unmodified, in order, with no drops and no duplicates.
REQ-020 SHALL keep three counters: chan (0..BPP-1), col (0..Matrix_Col-1) and row (0..Matrix_Row-1); each advances on an input handshake and wraps to 0 at its limit, carrying to the next counter.
REQ-021 SHALL set the rowlast tag when chan=BPP-1 and col=Matrix_Col-1, and the last tag when row=Matrix_Row-1 as well; tags travel with the data.
REQ-022 SHALL register output through a 2-entry skid buffer: 1-cycle latency from input handshake to mData_valid, sustained 1 beat/cycle when mData_ready is high, and sReady dependent only on registered state.
REQ-023 SHALL hold mData_payload, mData_rowlast and mData_last stable while mData_valid=1 and mData_ready=0.
REQ-024 SHALL stop accepting input after the last-tagged beat is accepted, even if sValid stays high.
REQ-025 SHALL, if any latched dimension is zero, go IDLE -> DONE directly, pulse LayerEnd and emit no beats.
REQ-026 SHALL handle In_Channel not a multiple of 8 via the ceiling only; padding lanes pass through untouched.

Reset
REQ-027 SHALL, on reset, drive FSM=IDLE, all counters=0, skid buffer empty, sReady=0, mData_valid=0, mData_rowlast=0, mData_last=0, LayerEnd=0, mData_payload=0.
REQ-028 SHALL let reset mid-layer abort immediately, discard buffered beats, assert no LayerEnd, and accept a new start on the first cycle after reset.

Structure
REQ-029 SHALL place DATA_W, DIM_W, LANES=8 and the FSM state encoding in the shared accelerator package.
REQ-030 SHALL implement the 2-entry buffer as one sub-module, stream_skid_buf, parameterised by payload width (DATA_W+2).

Verification
REQ-031 SHALL cover: In_Channel=32, Col=14, Row=14, both sides always ready -> 784 beats, rowlast on beats 56,112,...,784, last on beat 784 only, LayerEnd 1 cycle after the final handshake.
REQ-032 SHALL cover: In_Channel=12, Col=3, Row=2 -> BPP=2, 12 beats, rowlast on beats 6 and 12.
REQ-033 SHALL cover: mData_ready toggling on a 3-low/1-high pattern -> payload sequence identical to input, no loss, stable while stalled.
REQ-034 SHALL cover: Matrix_Row=0 -> zero output beats, single LayerEnd pulse, return to IDLE.
REQ-035 SHALL cover: reset asserted at beat 100 of 784, then restart -> new layer framing begins at beat 1, no LayerEnd from the aborted layer.
REQ-036 SHALL cover: start pulsed mid-RUN and sValid held high after the last beat -> start ignored, sReady=0 after last accept.
